// File: rtl/leaky_relu_stage_if.sv
// Signal bundle for one leaky_relu_stage column: forward stream, leak load chain
// and the derivative FIFO read side.
interface leaky_relu_stage_if #(
  parameter int DEPTH = 8
) ();
  localparam int CW = $clog2(DEPTH + 1);

  // Derivative read side: the head entry moves on any cycle where
  // deriv_valid_out && deriv_ready_in. valid never waits for ready.
  // The forward path has no backpressure.
  logic          lr_valid_in;
  logic [15:0]   lr_data_in;
  logic          load_leak_in;
  logic [15:0]   lr_leak_factor_in;
  logic          deriv_ready_in;
  logic          deriv_clear_in;

  logic [15:0]   lr_data_out;
  logic          lr_valid_out;
  logic          load_leak_out;
  logic [15:0]   lr_leak_factor_out;
  logic [15:0]   deriv_data_out;
  logic          deriv_valid_out;
  logic [CW-1:0] deriv_count_out;
  logic          deriv_overflow_out;

  modport master (
    output lr_valid_in, lr_data_in, load_leak_in, lr_leak_factor_in,
           deriv_ready_in, deriv_clear_in,
    input  lr_data_out, lr_valid_out, load_leak_out, lr_leak_factor_out,
           deriv_data_out, deriv_valid_out, deriv_count_out, deriv_overflow_out
  );

  modport slave (
    input  lr_valid_in, lr_data_in, load_leak_in, lr_leak_factor_in,
           deriv_ready_in, deriv_clear_in,
    output lr_data_out, lr_valid_out, load_leak_out, lr_leak_factor_out,
           deriv_data_out, deriv_valid_out, deriv_count_out, deriv_overflow_out
  );
endinterface

// File: rtl/leaky_relu_stage.sv
// Q8.8 leaky ReLU column stage: 2-cycle forward pipeline, per-column leak load
// chain and an in-order derivative FIFO drained by the backward pass.
module leaky_relu_stage #(
  parameter int DEPTH = 8
) (
  input logic             clk,
  input logic             rst,
  leaky_relu_stage_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [15:0]        leak_q;
  logic               load_out_q;
  logic [15:0]        leak_fwd_q;

  logic               s1_valid_q;
  logic signed [15:0] s1_x_q;
  logic signed [15:0] s1_leak_q;
  logic               out_valid_q;
  logic [15:0]        out_data_q;

  logic [15:0]        mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [CW-1:0]      count_q;
  logic               ovf_q;

  logic signed [31:0] prod;
  logic signed [31:0] shifted;
  logic [15:0]        y_d;
  logic [15:0]        deriv_d;
  logic               fifo_full, fifo_pop, fifo_push, fifo_drop;

  always_comb begin
    prod    = $signed({{16{s1_x_q[15]}}, s1_x_q}) * $signed({{16{s1_leak_q[15]}}, s1_leak_q});
    shifted = prod >>> 8;
    y_d     = s1_x_q;
    if (s1_x_q[15]) begin
      if (shifted > 32'sd32767)       y_d = 16'h7FFF;
      else if (shifted < -32'sd32768) y_d = 16'h8000;
      else                            y_d = shifted[15:0];
    end
  end

  // The derivative uses the leak as it was before any same-cycle load.
  always_comb begin
    deriv_d   = (!bus.lr_data_in[15] && (bus.lr_data_in != 16'h0000)) ? 16'h0100 : leak_q;
    fifo_full = (count_q == CW'(DEPTH));
    fifo_pop  = (count_q != '0) && bus.deriv_ready_in;
    fifo_push = bus.lr_valid_in && (!fifo_full || fifo_pop);
    fifo_drop = bus.lr_valid_in && fifo_full && !fifo_pop;
    wr_ptr_d  = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    rd_ptr_d  = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      leak_q      <= '0;
      load_out_q  <= 1'b0;
      leak_fwd_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s1_leak_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      load_out_q <= bus.load_leak_in;
      leak_fwd_q <= bus.lr_leak_factor_in;
      if (bus.load_leak_in) leak_q <= bus.lr_leak_factor_in;

      s1_valid_q <= bus.lr_valid_in;
      if (bus.lr_valid_in) begin
        s1_x_q    <= bus.lr_data_in;
        s1_leak_q <= leak_q;
      end
      out_valid_q <= s1_valid_q;
      out_data_q  <= s1_valid_q ? y_d : 16'h0000;

      if (bus.deriv_clear_in) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (fifo_push) wr_ptr_q <= wr_ptr_d;
        if (fifo_pop)  rd_ptr_q <= rd_ptr_d;
        if (fifo_push && !fifo_pop)      count_q <= count_q + CW'(1);
        else if (!fifo_push && fifo_pop) count_q <= count_q - CW'(1);
        if (fifo_drop) ovf_q <= 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (!rst && !bus.deriv_clear_in && fifo_push) mem_q[wr_ptr_q] <= deriv_d;
  end

  assign bus.lr_data_out        = out_data_q;
  assign bus.lr_valid_out       = out_valid_q;
  assign bus.load_leak_out      = load_out_q;
  assign bus.lr_leak_factor_out = leak_fwd_q;
  assign bus.deriv_valid_out    = (count_q != '0);
  assign bus.deriv_data_out     = (count_q != '0) ? mem_q[rd_ptr_q] : 16'h0000;
  assign bus.deriv_count_out    = count_q;
  assign bus.deriv_overflow_out = ovf_q;
endmodule

// File: tb/tb_leaky_relu_stage.sv
// Bench for leaky_relu_stage: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_leaky_relu_stage;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  leaky_relu_stage_if #(.DEPTH(DEPTH)) bus ();
  leaky_relu_stage #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model
  function automatic logic [15:0] act_model(input logic [15:0] x, input logic [15:0] k);
    int xi, ki, p;
    xi = int'($signed(x));
    ki = int'($signed(k));
    if (xi >= 0) return x;
    p = (xi * ki) >>> 8;
    if (p > 32767)  p = 32767;
    if (p < -32768) p = -32768;
    return p[15:0];
  endfunction

  function automatic logic [15:0] deriv_model(input logic [15:0] x, input logic [15:0] k);
    return (int'($signed(x)) > 0) ? 16'h0100 : k;
  endfunction

  logic [16:0] fwd_q[$];
  logic [16:0] cur_fwd;
  logic [15:0] exp_q[$];
  logic [15:0] mdl_leak;
  logic        mdl_ovf;
  logic        exp_load_out;
  logic [15:0] exp_leak_out;
  bit          model_ok = 0;

  always @(posedge clk) begin
    bit pop, full_before;
    if (rst) begin
      fwd_q        = {17'd0};
      cur_fwd      = 17'd0;
      exp_q.delete();
      mdl_leak     = 16'h0000;
      mdl_ovf      = 1'b0;
      exp_load_out = 1'b0;
      exp_leak_out = 16'h0000;
      model_ok     = 1;
    end else if (model_ok) begin
      cur_fwd = fwd_q.pop_front();
      fwd_q.push_back(bus.lr_valid_in ? {1'b1, act_model(bus.lr_data_in, mdl_leak)} : 17'd0);
      pop         = (exp_q.size() != 0) && bus.deriv_ready_in;
      full_before = (exp_q.size() == DEPTH);
      if (bus.deriv_clear_in) exp_q.delete();
      else begin
        if (pop) void'(exp_q.pop_front());
        if (bus.lr_valid_in) begin
          if (full_before && !pop) mdl_ovf = 1'b1;
          else exp_q.push_back(deriv_model(bus.lr_data_in, mdl_leak));
        end
      end
      if (bus.load_leak_in) mdl_leak = bus.lr_leak_factor_in;
      exp_load_out = bus.load_leak_in;
      exp_leak_out = bus.lr_leak_factor_in;
    end
  end

  // compare process
  always @(negedge clk) begin
    if (model_ok) begin
      check("lr_valid_out", bus.lr_valid_out, cur_fwd[16]);
      check("lr_data_out", bus.lr_data_out, cur_fwd[15:0]);
      check("load_leak_out", bus.load_leak_out, exp_load_out);
      check("lr_leak_factor_out", bus.lr_leak_factor_out, exp_leak_out);
      check("deriv_valid_out", bus.deriv_valid_out, exp_q.size() != 0);
      check("deriv_data_out", bus.deriv_data_out, (exp_q.size() != 0) ? exp_q[0] : 16'h0000);
      check("deriv_count_out", bus.deriv_count_out, exp_q.size());
      check("deriv_overflow_out", bus.deriv_overflow_out, mdl_ovf);
    end
  end

  // driver tasks
  task automatic idle_inputs();
    bus.lr_valid_in       = 1'b0;
    bus.lr_data_in        = 16'h0000;
    bus.load_leak_in      = 1'b0;
    bus.lr_leak_factor_in = 16'h0000;
    bus.deriv_ready_in    = 1'b0;
    bus.deriv_clear_in    = 1'b0;
  endtask

  task automatic load_leak(input logic [15:0] k);
    bus.load_leak_in = 1'b1; bus.lr_leak_factor_in = k; bus.lr_valid_in = 1'b0;
    tick();
    bus.load_leak_in = 1'b0;
  endtask

  task automatic send(input logic [15:0] x);
    bus.lr_valid_in = 1'b1; bus.lr_data_in = x;
    tick();
  endtask

  initial begin
    idle_inputs();
    check("pin_pos", act_model(16'h0300, 16'h0019), 16'h0300);
    check("pin_neg", act_model(16'hFE00, 16'h0019), 16'hFFCE);
    check("pin_zero", act_model(16'h0000, 16'h0019), 16'h0000);
    check("pin_sat_lo", act_model(16'h8000, 16'h0200), 16'h8000);
    check("pin_sat_hi", act_model(16'h8000, 16'hFE00), 16'h7FFF);
    check("pin_deriv_zero", deriv_model(16'h0000, 16'h0019), 16'h0019);

    rst = 1'b1; tick(); tick(); rst = 1'b0;
    check("rst_lr_valid", bus.lr_valid_out, 1'b0);
    check("rst_lr_data", bus.lr_data_out, 16'h0000);
    check("rst_deriv_valid", bus.deriv_valid_out, 1'b0);
    check("rst_deriv_count", bus.deriv_count_out, 0);
    check("rst_overflow", bus.deriv_overflow_out, 1'b0);
    check("rst_load_out", bus.load_leak_out, 1'b0);

    load_leak(16'h0019);
    check("chain_load", bus.load_leak_out, 1'b1);
    check("chain_factor", bus.lr_leak_factor_out, 16'h0019);
    send(16'h0300);
    send(16'hFE00);
    check("basic_pos", bus.lr_data_out, 16'h0300);
    send(16'h0000);
    check("basic_neg", bus.lr_data_out, 16'hFFCE);
    bus.lr_valid_in = 1'b0; tick();
    check("basic_zero", bus.lr_data_out, 16'h0000);
    check("basic_zero_valid", bus.lr_valid_out, 1'b1);
    check("basic_count", bus.deriv_count_out, 3);
    check("basic_head", bus.deriv_data_out, 16'h0100);
    tick();
    check("basic_idle_valid", bus.lr_valid_out, 1'b0);
    bus.deriv_ready_in = 1'b1; tick();
    check("pop1_head", bus.deriv_data_out, 16'h0019);
    check("pop1_count", bus.deriv_count_out, 2);
    tick();
    check("pop2_head", bus.deriv_data_out, 16'h0019);
    tick();
    check("pop3_valid", bus.deriv_valid_out, 1'b0);
    bus.deriv_ready_in = 1'b0;

    load_leak(16'h0200); send(16'h8000); bus.lr_valid_in = 1'b0; tick();
    check("sat_low", bus.lr_data_out, 16'h8000);
    load_leak(16'hFE00); send(16'h8000); bus.lr_valid_in = 1'b0; tick();
    check("sat_high", bus.lr_data_out, 16'h7FFF);

    load_leak(16'h0040);
    bus.load_leak_in = 1'b1; bus.lr_leak_factor_in = 16'h0080;
    send(16'hFF00);
    bus.load_leak_in = 1'b0;
    send(16'hFF00);
    check("order_old_leak", bus.lr_data_out, 16'hFFC0);
    bus.lr_valid_in = 1'b0; tick();
    check("order_new_leak", bus.lr_data_out, 16'hFF80);

    bus.deriv_clear_in = 1'b1; tick(); bus.deriv_clear_in = 1'b0;
    check("clear_count", bus.deriv_count_out, 0);
    for (int i = 0; i < 9; i++) send((i == 0) ? 16'h0200 : 16'hFF00 - 16'(i));
    bus.lr_valid_in = 1'b0;
    check("full_count", bus.deriv_count_out, DEPTH);
    check("full_overflow", bus.deriv_overflow_out, 1'b1);
    check("full_head", bus.deriv_data_out, 16'h0100);
    bus.deriv_ready_in = 1'b1; send(16'h0300);
    bus.lr_valid_in = 1'b0;
    check("pushpop_count", bus.deriv_count_out, DEPTH);
    check("pushpop_head", bus.deriv_data_out, 16'h0080);
    for (int i = 0; i < DEPTH; i++) tick();
    check("drain_valid", bus.deriv_valid_out, 1'b0);
    bus.deriv_ready_in = 1'b0;

    send(16'h0100);
    bus.deriv_clear_in = 1'b1; send(16'h0100);
    bus.deriv_clear_in = 1'b0; bus.lr_valid_in = 1'b0;
    check("clear_push_count", bus.deriv_count_out, 0);
    check("clear_push_valid", bus.deriv_valid_out, 1'b0);

    send(16'h0100);
    bus.lr_valid_in = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    check("rst_flush_now", bus.lr_valid_out, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_flush_later", bus.lr_valid_out, 1'b0);
    end

    for (int c = 0; c < 1500; c++) begin
      bus.lr_valid_in       = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 5))
        0:       bus.lr_data_in = 16'h8000;
        1:       bus.lr_data_in = 16'h0000;
        default: bus.lr_data_in = 16'($urandom);
      endcase
      bus.load_leak_in      = ($urandom_range(0, 9) == 0);
      bus.lr_leak_factor_in = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      bus.deriv_ready_in    = ($urandom_range(0, 2) == 0);
      bus.deriv_clear_in    = ($urandom_range(0, 49) == 0);
      rst                   = ($urandom_range(0, 199) == 0);
      tick();
    end
    idle_inputs(); rst = 1'b0;
    tick(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
